// File: rtl/rvc_pkg.sv
// rvc_pkg: RV32I/RVC encoding constants shared by the fetch aligner and the RVC expander.
package rvc_pkg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd2;
    typedef enum logic [1:0] {Q0 = 2'b00, Q1 = 2'b01, Q2 = 2'b10, Q3 = 2'b11} quad_e;
endpackage

// File: rtl/fetch_align_decompress_if.sv
// fetch_align_decompress_if: fetch-side, decode-side and redirect signals of the aligner.
interface fetch_align_decompress_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_data;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        d_compressed;
    logic        d_illegal;
    modport master (
        output flush, flush_pc, f_valid, f_data, d_ready,
        input  f_ready, d_valid, d_instr, d_pc, d_compressed, d_illegal
    );
    modport slave (
        input  flush, flush_pc, f_valid, f_data, d_ready,
        output f_ready, d_valid, d_instr, d_pc, d_compressed, d_illegal
    );
endinterface

// File: rtl/rvc_expander.sv
// rvc_expander: combinational RVC to RV32I expansion; illegal encodings return the raw halfword.
module rvc_expander
    import rvc_pkg::*;
(
    input  logic [15:0] c_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);
    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6s;
    logic [2:0]  alu_f3;
    logic [31:0] x;
    logic        ill, nz6;
    assign c      = c_i;
    assign rd     = c[11:7];
    assign rs2    = c[6:2];
    assign rdp    = {2'b01, c[4:2]};
    assign rs1p   = {2'b01, c[9:7]};
    assign imm6s  = {{7{c[12]}}, c[6:2]};
    assign nz6    = |{c[12], c[6:2]};
    assign alu_f3 = c[6:5] == 2'b00 ? F3_ADD : c[6:5] == 2'b01 ? F3_XOR : c[6:5] == 2'b10 ? F3_OR : F3_AND;
    always_comb begin
        x   = '0;
        ill = 1'b1;
        case ({c[1:0], c[15:13]})
            {Q0, 3'b000}: begin
                x   = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b0, REG_SP, F3_ADD, rdp, OP_IMM};
                ill = ~|c[12:5];
            end
            {Q0, 3'b010}: begin
                x   = {5'b0, c[5], c[12:10], c[6], 2'b0, rs1p, F3_W, rdp, LOAD};
                ill = 1'b0;
            end
            {Q0, 3'b110}: begin
                x   = {5'b0, c[5], c[12], rdp, rs1p, F3_W, c[11:10], c[6], 2'b0, STORE};
                ill = 1'b0;
            end
            {Q1, 3'b000}: begin
                x   = {imm6s, rd, F3_ADD, rd, OP_IMM};
                ill = 1'b0;
            end
            {Q1, 3'b001}, {Q1, 3'b101}: begin
                // c.jal links to ra, c.j discards the link
                x   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                       c[15] ? REG_ZERO : REG_RA, JAL};
                ill = 1'b0;
            end
            {Q1, 3'b010}: begin
                x   = {imm6s, REG_ZERO, F3_ADD, rd, OP_IMM};
                ill = 1'b0;
            end
            {Q1, 3'b011}: begin
                x   = rd == REG_SP ? {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, REG_SP, F3_ADD, REG_SP, OP_IMM}
                                   : {{15{c[12]}}, c[6:2], rd, LUI};
                ill = !nz6;
            end
            {Q1, 3'b100}: begin
                x   = !c[11] ? {c[10] ? F7_ALT : F7_BASE, c[6:2], rs1p, F3_SR, rs1p, OP_IMM}
                    : !c[10] ? {imm6s, rs1p, F3_AND, rs1p, OP_IMM}
                    : {c[6:5] == 2'b00 ? F7_ALT : F7_BASE, rdp, rs1p, alu_f3, rs1p, OP};
                ill = c[11:10] == 2'b10 ? 1'b0 : c[12];
            end
            {Q1, 3'b110}, {Q1, 3'b111}: begin
                x   = {c[12], {3{c[12]}}, c[6:5], c[2], REG_ZERO, rs1p, c[13] ? F3_BNE : F3_BEQ,
                       c[11:10], c[4:3], c[12], BRANCH};
                ill = 1'b0;
            end
            {Q2, 3'b000}: begin
                x   = {F7_BASE, c[6:2], rd, F3_SLL, rd, OP_IMM};
                ill = c[12];
            end
            {Q2, 3'b010}: begin
                x   = {4'b0, c[3:2], c[12], c[6:4], 2'b0, REG_SP, F3_W, rd, LOAD};
                ill = rd == REG_ZERO;
            end
            {Q2, 3'b100}: begin
                // rs2 == 0 selects jr/jalr (ebreak is left illegal), otherwise mv/add
                x   = rs2 == REG_ZERO ? {12'b0, rd, F3_ADD, c[12] ? REG_RA : REG_ZERO, JALR}
                                      : {F7_BASE, rs2, c[12] ? rd : REG_ZERO, F3_ADD, rd, OP};
                ill = rs2 == REG_ZERO && rd == REG_ZERO;
            end
            {Q2, 3'b110}: begin
                x   = {4'b0, c[8:7], c[12], rs2, REG_SP, F3_W, c[11:9], 2'b0, STORE};
                ill = 1'b0;
            end
            default: ill = 1'b1;
        endcase
    end
    assign instr_o   = ill ? {16'b0, c} : x;
    assign illegal_o = ill;
endmodule

// File: rtl/fetch_align_decompress.sv
// fetch_align_decompress: buffers fetch words as halfwords, aligns 16/32-bit instructions
// (including ones straddling two words) and hands decode one expanded instruction per cycle.
module fetch_align_decompress
    import rvc_pkg::*;
#(
    parameter int          BUF_HW   = 4,
    parameter bit          C_EXT    = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     rst_n,
    fetch_align_decompress_if.slave bus
);
    localparam int CW = $clog2(BUF_HW + 1);
    logic [BUF_HW-1:0][15:0] buf_q, buf_d, shifted;
    logic [BUF_HW+1:0][15:0] ext;
    logic [CW-1:0]           count_q, count_d, base;
    logic [31:0]             pc_q, pc_d, exp_instr;
    logic [15:0]             hw0;
    logic [1:0]              pop_n, push_n;
    logic                    drop_q, drop_d, head16, push, pop, exp_ill, raw_ill;
    rvc_expander u_exp (
        .c_i       (buf_q[0]),
        .instr_o   (exp_instr),
        .illegal_o (exp_ill)
    );
    assign head16  = C_EXT && (buf_q[0][1:0] != Q3);
    assign raw_ill = !C_EXT && (buf_q[0][1:0] != Q3);
    assign bus.d_valid      = head16 ? (count_q >= CW'(1)) : (count_q >= CW'(2));
    assign bus.d_instr      = !bus.d_valid ? '0 : head16 ? exp_instr : raw_ill ? {16'b0, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign bus.d_compressed = bus.d_valid && head16;
    assign bus.d_illegal    = bus.d_valid && (head16 ? exp_ill : raw_ill);
    assign bus.d_pc         = pc_q;
    assign bus.f_ready = rst_n && !bus.flush && (count_q <= CW'(BUF_HW - 2));
    assign pop    = bus.d_valid && bus.d_ready && !bus.flush;
    assign push   = bus.f_valid && bus.f_ready;
    assign pop_n  = !pop ? 2'd0 : head16 ? 2'd1 : 2'd2;
    assign push_n = !push ? 2'd0 : drop_q ? 2'd1 : 2'd2;
    assign hw0    = drop_q ? bus.f_data[31:16] : bus.f_data[15:0];
    // pop first, then append the new halfwords behind whatever survives
    assign ext     = {32'b0, buf_q};
    assign shifted = pop_n == 2'd2 ? ext[BUF_HW+1:2] : pop_n == 2'd1 ? ext[BUF_HW:1] : ext[BUF_HW-1:0];
    assign base    = count_q - CW'(pop_n);
    always_comb begin
        buf_d = shifted;
        for (int i = 0; i < BUF_HW; i++)
            buf_d[i] = (push && CW'(i) == base) ? hw0
                     : (push && !drop_q && CW'(i) == base + CW'(1)) ? bus.f_data[31:16] : shifted[i];
    end
    assign count_d = bus.flush ? '0 : count_q + CW'(push_n) - CW'(pop_n);
    assign pc_d    = bus.flush ? bus.flush_pc : pc_q + {29'b0, pop_n, 1'b0};
    assign drop_d  = bus.flush ? bus.flush_pc[1] : drop_q && !push;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_fetch_align_decompress.sv
// tb_fetch_align_decompress: directed checks of alignment, expansion, flush and backpressure
// on an RVC build and a C_EXT=0 build side by side.
module tb_fetch_align_decompress;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    fetch_align_decompress_if bc ();
    fetch_align_decompress_if bn ();
    fetch_align_decompress #(.BUF_HW(4), .C_EXT(1'b1), .RESET_PC(32'h0)) u_c (.clk(clk), .rst_n(rst_n), .bus(bc));
    fetch_align_decompress #(.BUF_HW(4), .C_EXT(1'b0), .RESET_PC(32'h0)) u_n (.clk(clk), .rst_n(rst_n), .bus(bn));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic out_c(input string tag, input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        chk({tag, "_valid"}, 32'(bc.d_valid), 32'd1);
        chk({tag, "_instr"}, bc.d_instr, instr);
        chk({tag, "_pc"}, bc.d_pc, pc);
        chk({tag, "_comp"}, 32'(bc.d_compressed), 32'(comp));
    endtask

    logic [15:0] hw [10] = '{16'h852E, 16'h157D, 16'h8082, 16'h4188, 16'hC501,
                             16'h9101, 16'h2011, 16'h0020, 16'h0000, 16'h0001};
    logic [31:0] ex [10] = '{32'h00B00533, 32'hFFF50513, 32'h00008067, 32'h0005A503, 32'h00050463,
                             32'h00009101, 32'h004000EF, 32'h00810413, 32'h00000000, 32'h00000013};
    logic        il [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        bc.flush = 0; bc.flush_pc = 0; bc.f_valid = 0; bc.f_data = 0; bc.d_ready = 0;
        bn.flush = 0; bn.flush_pc = 0; bn.f_valid = 0; bn.f_data = 0; bn.d_ready = 1;
        #3;
        chk("rst_fready", 32'(bc.f_ready), 32'd0);
        chk("rst_dvalid", 32'(bc.d_valid), 32'd0);
        chk("rst_instr", bc.d_instr, 32'd0);
        chk("rst_comp", 32'(bc.d_compressed), 32'd0);
        chk("rst_ill", 32'(bc.d_illegal), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        chk("rst_pc", bc.d_pc, 32'd0);
        chk("post_rst_fready", 32'(bc.f_ready), 32'd1);

        // two compressed instructions from one word; C_EXT=0 build flags the same word illegal
        bc.d_ready = 1;
        bc.f_valid = 1; bc.f_data = 32'h4515_0001;
        bn.f_valid = 1; bn.f_data = 32'h4515_0001;
        tick;
        bc.f_valid = 0; bn.f_valid = 0;
        out_c("nop", 32'h00000013, 32'h0, 1'b1);
        chk("n_valid", 32'(bn.d_valid), 32'd1);
        chk("n_ill", 32'(bn.d_illegal), 32'd1);
        chk("n_pc", bn.d_pc, 32'd0);
        chk("n_comp", 32'(bn.d_compressed), 32'd0);
        tick;
        out_c("li", 32'h00500513, 32'h2, 1'b1);
        chk("n_empty", 32'(bn.d_valid), 32'd0);
        chk("n_pc4", bn.d_pc, 32'd4);
        tick;
        chk("empty_valid", 32'(bc.d_valid), 32'd0);
        chk("empty_instr", bc.d_instr, 32'd0);
        chk("empty_pc", bc.d_pc, 32'd4);

        // 32-bit instruction straddling two fetch words
        bc.f_valid = 1; bc.f_data = 32'h0513_4515;
        tick;
        bc.f_valid = 0;
        out_c("str_li", 32'h00500513, 32'h4, 1'b1);
        tick;
        chk("str_half_valid", 32'(bc.d_valid), 32'd0);
        chk("str_half_pc", bc.d_pc, 32'h6);
        bc.f_valid = 1; bc.f_data = 32'h0001_0050;
        tick;
        bc.f_valid = 0;
        out_c("str_32", 32'h00500513, 32'h6, 1'b0);
        tick;
        out_c("str_nop", 32'h00000013, 32'hA, 1'b1);
        tick;
        chk("str_done", 32'(bc.d_valid), 32'd0);

        // half-buffered straddle discarded by a flush to an odd halfword target
        bc.f_valid = 1; bc.f_data = 32'h0513_4515;
        tick;
        bc.f_valid = 0;
        tick;
        chk("fl_half_valid", 32'(bc.d_valid), 32'd0);
        bc.flush = 1; bc.flush_pc = 32'h102; bc.f_valid = 1; bc.f_data = 32'hFFFF_FFFF;
        #1;
        chk("fl_fready", 32'(bc.f_ready), 32'd0);
        tick;
        bc.flush = 0; bc.f_valid = 0;
        chk("fl_valid", 32'(bc.d_valid), 32'd0);
        chk("fl_pc", bc.d_pc, 32'h102);
        bc.f_valid = 1; bc.f_data = 32'h4515_0001;
        tick;
        bc.f_valid = 0;
        out_c("fl_li", 32'h00500513, 32'h102, 1'b1);
        tick;
        chk("fl_drained", 32'(bc.d_valid), 32'd0);
        chk("fl_pc2", bc.d_pc, 32'h104);

        // backpressure with 32-bit words, then release
        bc.flush = 1; bc.flush_pc = 32'h0;
        tick;
        bc.flush = 0;
        bc.d_ready = 0;
        bc.f_valid = 1; bc.f_data = 32'h0050_0513;
        tick;
        chk("bp_fready_2", 32'(bc.f_ready), 32'd1);
        tick;
        chk("bp_fready_full", 32'(bc.f_ready), 32'd0);
        out_c("bp_hold", 32'h00500513, 32'h0, 1'b0);
        tick;
        chk("bp_still_full", 32'(bc.f_ready), 32'd0);
        chk("bp_still_pc", bc.d_pc, 32'h0);
        bc.d_ready = 1;
        tick;
        out_c("bp_pc4", 32'h00500513, 32'h4, 1'b0);
        chk("bp_fready_rel", 32'(bc.f_ready), 32'd1);
        tick;
        out_c("bp_pc8", 32'h00500513, 32'h8, 1'b0);
        tick;
        out_c("bp_pcC", 32'h00500513, 32'hC, 1'b0);
        bc.f_valid = 0;
        tick;
        chk("bp_empty", 32'(bc.d_valid), 32'd0);
        chk("bp_pc10", bc.d_pc, 32'h10);

        // expansion table, two compressed instructions per word
        for (int k = 0; k < 5; k++) begin
            bc.f_valid = 1; bc.f_data = {hw[2*k+1], hw[2*k]};
            tick;
            bc.f_valid = 0;
            for (int j = 0; j < 2; j++) begin
                out_c($sformatf("vec%0d", 2*k+j), ex[2*k+j], 32'h10 + 32'(4*k + 2*j), 1'b1);
                chk($sformatf("vec%0d_ill", 2*k+j), 32'(bc.d_illegal), 32'(il[2*k+j]));
                tick;
            end
        end
        chk("vec_done", 32'(bc.d_valid), 32'd0);

        // asynchronous reset in the middle of a stream
        bc.f_valid = 1; bc.f_data = 32'h4515_0001;
        tick;
        bc.f_valid = 0;
        chk("mid_valid_before", 32'(bc.d_valid), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_valid", 32'(bc.d_valid), 32'd0);
        chk("mid_pc", bc.d_pc, 32'd0);
        chk("mid_fready", 32'(bc.f_ready), 32'd0);
        #1;
        rst_n = 1;
        tick;
        chk("mid_lost", 32'(bc.d_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_align_decompress.md
Name: fetch_align_decompress

Overview:
- Sits between instruction memory and decode in IF.
- Accepts a stream of word-aligned 32-bit fetch words and buffers them as halfwords.
- Splits the buffer into 16/32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Expands RVC instructions to RV32I, then presents one 32-bit instruction per cycle with its PC under valid/ready handshakes on both sides.

Parameters:
- BUF_HW, 4, halfword buffer depth; legal values 4..8, even.
- C_EXT, 1, 1 = RVC expansion enabled; 0 = every halfword pair treated as 32-bit, and a non-11 low opcode is flagged illegal.
- RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect: discard buffer, restart at flush_pc
- flush_pc  in  32  redirect target, halfword aligned
- f_valid  in  1  fetch word valid
- f_ready  out  1  block can accept fetch word
- f_data  in  32  fetch word; halfword 0 = bits 15:0 (lower address)
- d_valid  out  1  instruction available
- d_ready  in  1  decode accepts instruction
- d_instr  out  32  expanded (or raw 32-bit) instruction
- d_pc  out  32  address of the instruction
- d_compressed  out  1  instruction came from a 16-bit encoding
- d_illegal  out  1  reserved/illegal compressed encoding; d_instr = zero-extended raw halfword

Behaviour:
- State:
  - halfword buffer buf[BUF_HW], FIFO order
  - count, 0..BUF_HW
  - pc register
  - drop_hw flag
- Reset (async, rst_n=0):
  - count=0, drop_hw=0, pc=RESET_PC
  - f_ready=0 while in reset
  - d_valid=0; d_instr=0, d_compressed=0, d_illegal=0
- Fetch side:
  - f_ready = !flush && (count <= BUF_HW-2), evaluated on the pre-pop count.
  - Word accepted on f_valid&&f_ready at a rising edge.
  - If drop_hw=1, only f_data[31:16] is pushed and drop_hw clears.
  - Otherwise both halfwords are pushed, low first.
- Decode side:
  - d_* are combinational from buffer head; a word accepted at edge N is visible at d_* after edge N.
  - Head is 16-bit when C_EXT=1 and buf[0][1:0]!=2'b11; otherwise 32-bit.
  - d_valid = (16-bit && count>=1) || (32-bit && count>=2).
  - All d_* except d_pc are 0 when d_valid=0.
  - 32-bit result: {buf[1],buf[0]}.
- Pop on d_valid&&d_ready: remove 1 or 2 halfwords; pc += 2 or 4.
- Push and pop in the same cycle are both performed; count = count + pushed − popped, never exceeds BUF_HW.
- Expansion covers:
  - addi4spn, lw, sw, nop, addi, jal, li, addi16sp, lui
  - srli, srai, andi, sub, xor, or, and
  - j, beqz, bnez
  - slli, lwsp, swsp, jr, jalr, mv, add
- Expansion uses standard RV32C immediate scrambling with sign extension as in the ISA spec.
- d_illegal=1 for:
  - all-zero halfword
  - addi4spn with nzuimm=0
  - lwsp or jr with rd/rs1=0
  - addi16sp with imm=0
  - lui with imm=0
  - slli/srli/srai with shamt[5]=1
  - any encoding not in the expansion list
  - C_EXT=0 with low bits !=11
- Flush (highest priority):
  - At the edge: count=0, pc=flush_pc, drop_hw=flush_pc[1].
  - Any same-cycle fetch acceptance and decode pop are ignored (f_ready=0 during the flush cycle).
- Flush while a straddling 32-bit instruction is half-buffered: the half is discarded, no output.
- Reset mid-operation: immediate return to reset state; buffered halfwords are lost.

Decomposition:
- Package rvc_pkg holds:
  - RV32I opcode constants (OP_IMM, OP, LOAD, STORE, LUI, JAL, JALR, BRANCH)
  - funct3/funct7 constants
  - compressed quadrant constants
  - REG_SP=5'd2, REG_RA=5'd1
- Sub-module rvc_expander: purely combinational, 16-bit in → 32-bit instr + illegal flag.
- Top holds buffer, counters, pc, handshakes.

Test Plan:
- Reset then word 0x4515_0001, d_ready=1:
  - cycle 1: d_instr=0x00000013, d_pc=0x0, compressed=1
  - cycle 2: d_instr=0x00500513, d_pc=0x2
- Straddle: word0 0x0513_4515, word1 0xXXXX_0050:
  - 0x00500513 at pc0 (compressed)
  - then 0x00500513 at pc2, compressed=0, emitted only after word1 accepted
- Flush to 0x102, then word 0x4515_0001:
  - 0x0001 dropped
  - first output 0x00500513 at d_pc=0x102
- Backpressure: d_ready=0, feed 32-bit words 0x00500513:
  - f_ready=0 once count>BUF_HW-2 (after 2 words at BUF_HW=4)
  - no loss after releasing d_ready; pcs 0,4,8…
- Illegal: halfword 0x0000 → d_valid=1, d_illegal=1, d_instr=0x00000000.
- C_EXT=0 build: word 0x4515_0001 → d_illegal=1, d_pc=0.
- Simultaneous push/pop at count=2 keeps throughput at 1 instr/cycle.
- Reset asserted mid-stream clears d_valid immediately.
